// File: rtl/mem_pkg.sv
// Shared types for mem_handle clients: address/data widths, handle bundle and reader FSM states.
package mem_pkg;

  localparam int ADDR_SIZE = 23;
  localparam int DATA_SIZE = 32;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] region_begin;
    logic [ADDR_SIZE-1:0] region_end;
    logic [ADDR_SIZE-1:0] ptr;
    logic                 r_en;
    logic                 w_en;
    logic                 read_through;
    logic                 write_through;
  } mem_handle_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DRAIN,
    ST_FINISH
  } reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; a push while full is accepted only if a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_region_reader.sv
// Reads words begin..end (inclusive) through a mem_handle, one request in flight, into a prefetch FIFO.
module mem_region_reader
  import mem_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter bit READ_THROUGH = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] cfg_begin,
  input  logic [ADDR_SIZE-1:0] cfg_end,
  output logic                 busy,
  output logic                 finished,
  output logic                 err,
  output logic [ADDR_SIZE-1:0] mh_region_begin,
  output logic [ADDR_SIZE-1:0] mh_region_end,
  output logic [ADDR_SIZE-1:0] mh_ptr,
  output logic                 mh_r_en,
  output logic                 mh_w_en,
  output logic                 mh_read_through,
  output logic                 mh_write_through,
  input  logic                 mh_avail,
  input  logic                 mh_done,
  input  logic [DATA_SIZE-1:0] mh_data,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reader_state_t        state_reg, state_next;
  logic [ADDR_SIZE-1:0] begin_reg, end_reg, ptr_reg;
  logic                 err_reg;
  logic                 done_gap_reg;
  logic                 r_en, push, pop, credit;
  logic                 fifo_empty, fifo_full;
  logic [CW-1:0]        fifo_count;
  mem_handle_t          mh;

  // Credit uses the registered count only, so a pop in the same cycle never enables an extra read.
  assign credit = !fifo_full;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    r_en       = 1'b0;
    push       = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CHECK;
      ST_CHECK: state_next = (end_reg < begin_reg) ? ST_FINISH : ST_ISSUE;
      // done_gap_reg forces r_en low for one cycle after every completed read.
      ST_ISSUE: begin
        if (mh_avail && credit && !done_gap_reg) begin
          r_en       = 1'b1;
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        r_en = 1'b1;
        if (mh_done) begin
          push       = 1'b1;
          state_next = (ptr_reg == end_reg) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_DRAIN:  if (fifo_count == '0) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      begin_reg    <= '0;
      end_reg      <= '0;
      ptr_reg      <= '0;
      err_reg      <= 1'b0;
      done_gap_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_gap_reg <= push;
      if (state_reg == ST_IDLE && start) begin
        begin_reg <= cfg_begin;
        end_reg   <= cfg_end;
        err_reg   <= 1'b0;
      end
      if (state_reg == ST_CHECK) begin
        if (end_reg < begin_reg) err_reg <= 1'b1;
        else                     ptr_reg <= begin_reg;
      end
      // Compare against end before incrementing so the top address never wraps.
      if (push && ptr_reg != end_reg) begin
        ptr_reg <= ptr_reg + ADDR_SIZE'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH(DATA_SIZE),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(mh_data),
    .pop      (pop),
    .head     (out_data),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign mh = '{region_begin:  begin_reg,
                region_end:    end_reg,
                ptr:           ptr_reg,
                r_en:          r_en,
                w_en:          1'b0,
                read_through:  READ_THROUGH,
                write_through: 1'b0};

  assign mh_region_begin  = mh.region_begin;
  assign mh_region_end    = mh.region_end;
  assign mh_ptr           = mh.ptr;
  assign mh_r_en          = mh.r_en;
  assign mh_w_en          = mh.w_en;
  assign mh_read_through  = mh.read_through;
  assign mh_write_through = mh.write_through;

  assign busy      = (state_reg != ST_IDLE);
  assign finished  = (state_reg == ST_FINISH);
  assign err       = err_reg;
  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_mem_region_reader.sv
// Randomized bench for mem_region_reader: memory responder, stream consumer and address-list reference model.
module tb_mem_region_reader;
  import mem_pkg::*;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [DATA_SIZE-1:0] word_t;

  logic  clock = 1'b0;
  logic  reset, start, mh_avail, mh_done, out_ready;
  addr_t cfg_begin, cfg_end;
  word_t mh_data;
  logic  busy, finished, err, mh_r_en, mh_w_en, mh_read_through, mh_write_through, out_valid;
  addr_t mh_region_begin, mh_region_end, mh_ptr;
  word_t out_data;

  mem_region_reader #(.FIFO_DEPTH(4), .READ_THROUGH(1'b0)) dut (
    .clock(clock), .reset(reset), .start(start), .cfg_begin(cfg_begin), .cfg_end(cfg_end),
    .busy(busy), .finished(finished), .err(err),
    .mh_region_begin(mh_region_begin), .mh_region_end(mh_region_end), .mh_ptr(mh_ptr),
    .mh_r_en(mh_r_en), .mh_w_en(mh_w_en), .mh_read_through(mh_read_through),
    .mh_write_through(mh_write_through), .mh_avail(mh_avail), .mh_done(mh_done),
    .mh_data(mh_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int    n_checks = 0, n_pass = 0;
  int    cyc = 0, start_cyc, first_ren_cyc, first_valid_cyc, fin_cyc, fin_cnt = 0, fin_snap;
  logic  fin_err;
  int    ptr_unstable;
  int    avail_mode = 1, ready_mode = 1, done_limit = -1, late_req = 0, late_served = 0;
  bit    spur_en = 0;
  word_t salt = 32'h0;
  addr_t issued_q[$];
  word_t recv_q[$];

  function automatic word_t word_of(input addr_t a);
    return {{(DATA_SIZE-ADDR_SIZE){1'b0}}, a} ^ salt;
  endfunction

  // Memory responder, consumer and monitor in one process: done one cycle after each new r_en.
  initial begin
    logic  in_req, armed, just_done;
    addr_t req_ptr;
    in_req = 0; armed = 0; just_done = 0; req_ptr = '0;
    mh_done = 0; mh_data = '0; mh_avail = 1; out_ready = 1;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      mh_done = 1'b0;
      if (armed) begin
        mh_done = 1; mh_data = word_of(req_ptr); armed = 0; just_done = 1;
      end else if (just_done && spur_en) begin
        mh_done = 1; mh_data = ~word_of(req_ptr); just_done = 0;
      end else if (late_served != late_req) begin
        mh_done = 1; mh_data = 32'hDEAD_BEEF; late_served++; just_done = 0;
      end else begin
        just_done = 0;
      end
      mh_avail  = (avail_mode == 2) ? 1'($urandom_range(0, 1)) : (avail_mode == 1);
      out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
      @(negedge clock);
      if (mh_r_en && !in_req) begin
        in_req = 1; req_ptr = mh_ptr; issued_q.push_back(mh_ptr);
        if (first_ren_cyc < 0) first_ren_cyc = cyc;
        if (done_limit < 0 || issued_q.size() <= done_limit) armed = 1;
      end else if (!mh_r_en) begin
        in_req = 0;
      end
      if (mh_r_en && in_req && mh_ptr != req_ptr) ptr_unstable++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) recv_q.push_back(out_data);
      if (finished) begin fin_cnt++; fin_cyc = cyc; fin_err = err; end
    end
  end

  task automatic clear_logs();
    issued_q.delete(); recv_q.delete();
    first_ren_cyc = -1; first_valid_cyc = -1; fin_cyc = -1; fin_err = 1'bx;
    ptr_unstable = 0; fin_snap = fin_cnt; salt = $urandom;
  endtask

  task automatic pulse_start(input addr_t b, input addr_t e);
    @(posedge clock); #1;
    cfg_begin = b; cfg_end = e; start = 1; start_cyc = cyc;
    @(posedge clock); #1;
    start = 0;
  endtask

  task automatic wait_fin(input int bound, output bit ok);
    int n = 0;
    while (fin_cnt == fin_snap && n < bound) begin @(posedge clock); n++; end
    #1;
    ok = (fin_cnt != fin_snap);
  endtask

  task automatic test_reset();
    reset = 1; start = 0; cfg_begin = '0; cfg_end = '0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if ({busy, finished, err, mh_r_en, out_valid} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000", {busy, finished, err, mh_r_en, out_valid}); else n_pass++;
    n_checks++; if ({mh_ptr, mh_region_begin, mh_region_end} !== '0)
      $display("FAIL reset_regs: got %h/%h/%h required 0", mh_ptr, mh_region_begin, mh_region_end); else n_pass++;
    n_checks++; if ({mh_w_en, mh_read_through, mh_write_through} !== 3'b000)
      $display("FAIL handle_ties: got %b required 000", {mh_w_en, mh_read_through, mh_write_through}); else n_pass++;
    reset = 0;
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs(); avail_mode = 1; ready_mode = 1;
    pulse_start(23'h10, 23'h13);
    wait_fin(100, ok);
    n_checks++; if (!ok) $display("FAIL basic_finish: got none required 1 finished pulse"); else n_pass++;
    n_checks++; if (issued_q.size() != 4) $display("FAIL basic_reads: got %0d required 4", issued_q.size()); else n_pass++;
    for (int i = 0; i < issued_q.size() && i < 4; i++) begin
      n_checks++; if (issued_q[i] !== addr_t'(23'h10 + i))
        $display("FAIL basic_ptr%0d: got %h required %h", i, issued_q[i], 23'h10 + i); else n_pass++;
    end
    n_checks++; if (recv_q.size() != 4) $display("FAIL basic_words: got %0d required 4", recv_q.size()); else n_pass++;
    for (int i = 0; i < recv_q.size() && i < 4; i++) begin
      n_checks++; if (recv_q[i] !== word_of(addr_t'(23'h10 + i)))
        $display("FAIL basic_word%0d: got %h required %h", i, recv_q[i], word_of(addr_t'(23'h10 + i))); else n_pass++;
    end
    n_checks++; if (first_ren_cyc - start_cyc != 2 || first_valid_cyc - start_cyc != 4)
      $display("FAIL basic_latency: got r_en@%0d valid@%0d required 2/4",
               first_ren_cyc - start_cyc, first_valid_cyc - start_cyc); else n_pass++;
    n_checks++; if (fin_err !== 1'b0) $display("FAIL basic_err: got %b required 0", fin_err); else n_pass++;
    $display("basic: %0d reads, %0d words, finished@+%0d", issued_q.size(), recv_q.size(), fin_cyc - start_cyc);
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs(); avail_mode = 1; ready_mode = 0;
    pulse_start(23'h10, 23'h17);
    repeat (40) @(posedge clock);
    #1;
    n_checks++; if (issued_q.size() != 4) $display("FAIL bp_credit: got %0d reads required 4", issued_q.size()); else n_pass++;
    n_checks++; if (mh_r_en !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_stall: got r_en=%b valid=%b required 0/1", mh_r_en, out_valid); else n_pass++;
    ready_mode = 1;
    wait_fin(200, ok);
    n_checks++; if (!ok) $display("FAIL bp_finish: got none required 1 finished pulse"); else n_pass++;
    n_checks++; if (recv_q.size() != 8 || issued_q.size() != 8)
      $display("FAIL bp_count: got %0d words %0d reads required 8/8", recv_q.size(), issued_q.size()); else n_pass++;
    for (int i = 0; i < recv_q.size() && i < 8; i++) begin
      n_checks++; if (recv_q[i] !== word_of(addr_t'(23'h10 + i)))
        $display("FAIL bp_word%0d: got %h required %h", i, recv_q[i], word_of(addr_t'(23'h10 + i))); else n_pass++;
    end
    $display("backpressure: %0d reads, %0d words", issued_q.size(), recv_q.size());
  endtask

  task automatic test_error();
    bit ok;
    clear_logs(); avail_mode = 1; ready_mode = 1;
    pulse_start(23'h20, 23'h1F);
    wait_fin(20, ok);
    n_checks++; if (!ok || fin_cyc - start_cyc != 2)
      $display("FAIL err_timing: got finished@+%0d required +2", fin_cyc - start_cyc); else n_pass++;
    n_checks++; if (fin_err !== 1'b1) $display("FAIL err_flag: got %b required 1", fin_err); else n_pass++;
    n_checks++; if (issued_q.size() != 0 || recv_q.size() != 0)
      $display("FAIL err_reads: got %0d reads %0d words required 0/0", issued_q.size(), recv_q.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL err_busy: got %b required 0", busy); else n_pass++;
    $display("error: finished@+%0d err=%b reads=%0d", fin_cyc - start_cyc, fin_err, issued_q.size());
  endtask

  task automatic test_top_address();
    bit ok;
    clear_logs(); avail_mode = 1; ready_mode = 1;
    pulse_start(23'h7FFFFF, 23'h7FFFFF);
    wait_fin(50, ok);
    n_checks++; if (!ok || fin_cyc - start_cyc != 6 || first_ren_cyc - start_cyc != 2 || first_valid_cyc - start_cyc != 4)
      $display("FAIL top_latency: got r_en@%0d valid@%0d fin@%0d required 2/4/6",
               first_ren_cyc - start_cyc, first_valid_cyc - start_cyc, fin_cyc - start_cyc); else n_pass++;
    n_checks++; if (issued_q.size() != 1 || issued_q[0] !== 23'h7FFFFF)
      $display("FAIL top_read: got %0d reads required 1 at 7fffff", issued_q.size()); else n_pass++;
    n_checks++; if (recv_q.size() != 1 || recv_q[0] !== word_of(23'h7FFFFF))
      $display("FAIL top_word: got %0d words required 1 of %h", recv_q.size(), word_of(23'h7FFFFF)); else n_pass++;
    n_checks++; if (mh_ptr !== 23'h7FFFFF) $display("FAIL top_nowrap: got %h required 7fffff", mh_ptr); else n_pass++;
    n_checks++; if (fin_err !== 1'b0) $display("FAIL top_err: got %b required 0", fin_err); else n_pass++;
    $display("top: ptr=%h words=%0d", mh_ptr, recv_q.size());
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs(); avail_mode = 1; ready_mode = 0; done_limit = 2;
    pulse_start(23'h40, 23'h47);
    while (issued_q.size() < 3 && n < 60) begin @(posedge clock); n++; end
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (issued_q.size() != 3 || mh_r_en !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL mid_setup: got reads=%0d r_en=%b valid=%b required 3/1/1", issued_q.size(), mh_r_en, out_valid); else n_pass++;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    n_checks++; if ({mh_r_en, out_valid, busy} !== 3'b000)
      $display("FAIL mid_abort: got r_en/valid/busy=%b required 000", {mh_r_en, out_valid, busy}); else n_pass++;
    late_req++;
    repeat (4) @(posedge clock);
    #1;
    n_checks++; if (out_valid !== 1'b0 || recv_q.size() != 0)
      $display("FAIL mid_late_done: got valid=%b words=%0d required 0/0", out_valid, recv_q.size()); else n_pass++;
    n_checks++; if (fin_cnt != fin_snap) $display("FAIL mid_nofinish: got %0d pulses required 0", fin_cnt - fin_snap); else n_pass++;
    done_limit = -1; ready_mode = 1;
    $display("reset_mid: reads=%0d valid=%b busy=%b", issued_q.size(), out_valid, busy);
  endtask

  task automatic test_spurious();
    bit ok;
    clear_logs(); avail_mode = 1; ready_mode = 2; spur_en = 1;
    pulse_start(23'h30, 23'h35);
    repeat (4) @(posedge clock);
    #1;
    cfg_begin = 23'h100; cfg_end = 23'h105; start = 1;
    @(posedge clock); #1;
    start = 0;
    wait_fin(200, ok);
    repeat (15) @(posedge clock);
    #1;
    spur_en = 0;
    n_checks++; if (!ok || fin_cnt - fin_snap != 1)
      $display("FAIL spur_finish: got %0d pulses required 1", fin_cnt - fin_snap); else n_pass++;
    n_checks++; if (mh_region_begin !== 23'h30 || mh_region_end !== 23'h35)
      $display("FAIL spur_relatch: got %h..%h required 30..35", mh_region_begin, mh_region_end); else n_pass++;
    n_checks++; if (recv_q.size() != 6) $display("FAIL spur_count: got %0d required 6", recv_q.size()); else n_pass++;
    for (int i = 0; i < recv_q.size() && i < 6; i++) begin
      n_checks++; if (recv_q[i] !== word_of(addr_t'(23'h30 + i)))
        $display("FAIL spur_word%0d: got %h required %h", i, recv_q[i], word_of(addr_t'(23'h30 + i))); else n_pass++;
    end
    n_checks++; if (ptr_unstable != 0) $display("FAIL spur_ptr_hold: got %0d changes required 0", ptr_unstable); else n_pass++;
    $display("spurious: %0d words, %0d finished", recv_q.size(), fin_cnt - fin_snap);
  endtask

  task automatic test_random();
    bit    ok;
    int    len;
    addr_t b;
    for (int it = 0; it < 6; it++) begin
      clear_logs(); avail_mode = 2; ready_mode = 2;
      len = $urandom_range(1, 9);
      b   = addr_t'($urandom_range(0, (1 << ADDR_SIZE) - 1 - len));
      pulse_start(b, addr_t'(b + len - 1));
      wait_fin(400, ok);
      n_checks++; if (!ok || recv_q.size() != len || issued_q.size() != len)
        $display("FAIL rnd%0d_count: got %0d words %0d reads required %0d", it, recv_q.size(), issued_q.size(), len); else n_pass++;
      for (int i = 0; i < recv_q.size() && i < len; i++) begin
        n_checks++; if (recv_q[i] !== word_of(addr_t'(b + i)))
          $display("FAIL rnd%0d_word%0d: got %h required %h", it, i, recv_q[i], word_of(addr_t'(b + i))); else n_pass++;
      end
      n_checks++; if (ptr_unstable != 0) $display("FAIL rnd%0d_ptr_hold: got %0d changes required 0", it, ptr_unstable); else n_pass++;
      $display("random %0d: begin=%h len=%0d words=%0d", it, b, len, recv_q.size());
    end
    avail_mode = 1; ready_mode = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_top_address();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
